unary_prod_decoder: RTL and testbench
=====================================

// Module: unary_prod_decoder
// PURPOSE
//  Receiving end of the Product_Block serial output. Product_Block encodes w*x as a count of
//  1-cycles on its 1-bit 'out' line inside a fixed frame opened by a start strobe. This block
//  counts those pulses over the frame and returns the binary product on a valid/ready port,
//  so the array controller reads products without tracking pulses itself.
// PARAMETERS
//  WINDOW  256  frame length in cycles; spike_in is sampled on each of these cycles (>=1)
//  CNT_W   8    result width; count saturates at 2**CNT_W-1
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      synchronous active-low reset
//  start         in   1      1-cycle strobe: frame begins on the following cycle
//  spike_in      in   1      pulse line from Product_Block 'out'
//  result        out  CNT_W  decoded pulse count; stable while result_valid=1
//  result_valid  out  1      result available
//  result_ready  in   1      consumer accepts result when result_valid&result_ready
//  busy          out  1      1 in COUNT state
//  overflow      out  1      count saturated this frame; valid with result
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE; result=0, result_valid=0, busy=0, overflow=0,
//    count and window counter cleared. Reset mid-frame or mid-HOLD drops the frame; no output.
//  - FSM: IDLE --start--> COUNT --WINDOW samples done--> HOLD --accepted--> IDLE.
//  - IDLE: spike_in ignored. start=1 -> COUNT next cycle; count cleared to 0.
//  - COUNT: busy=1. Exactly WINDOW cycles, starting the cycle after start. Each cycle with
//    spike_in=1 adds 1 to count. Spike on the start cycle itself is NOT counted.
//  - Saturation: at count=2**CNT_W-1 further spikes hold count and set overflow=1.
//  - start during COUNT: ignored; frame continues unchanged.
//  - Window end: the cycle after the last sample, result=count, result_valid=1, state=HOLD.
//    Latency start->result_valid = WINDOW+1 cycles.
//  - HOLD: result/overflow held while result_ready=0; spike_in ignored; start ignored unless
//    the result is accepted in the same cycle.
//  - Acceptance (result_valid&result_ready): result_valid=0 next cycle. If start=1 in the
//    same cycle, go directly to COUNT (back-to-back frames, no idle gap); else IDLE.
//  - result and overflow keep their last values after acceptance (don't-care when invalid).
//  - Window counter width clog2(WINDOW+1); WINDOW=1 must work (single sample).
// TESTING
//  1 reset: hold reset_n=0 2 cycles -> result_valid=0, busy=0, overflow=0, result=0.
//  2 basic: start, then 6 spikes (3*2) anywhere in window, result_ready=1 -> result_valid at
//    start+257, result=6, overflow=0, busy low after window.
//  3 saturate: start, spike_in=1 all 256 cycles -> result=255, overflow=1.
//  4 backpressure: result_ready=0 for 10 cycles after valid, start pulsed meanwhile ->
//    result held stable, start ignored; on accept returns to IDLE.
//  5 back-to-back: start coincident with acceptance -> new frame counts from next cycle;
//    spike on start cycle excluded; second result correct and independent of first.
//  6 reset mid-frame: reset_n=0 at window cycle 100 -> no result_valid; next frame result
//    counts only its own spikes. Also WINDOW=1 build: 1 spike -> result=1 at start+2.

Source files
------------

// File: rtl/unary_prod_decoder.sv
// unary_prod_decoder: counts spike_in pulses over a WINDOW-cycle frame
// opened by start, then offers the saturated count on a valid/ready port.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        1-cycle strobe, frame samples begin on the next cycle
//   spike_in     pulse line from Product_Block 'out'
//   result       decoded pulse count, stable while result_valid=1
//   result_valid result available
//   result_ready consumer accepts on result_valid & result_ready
//   busy         high while the frame is being counted
//   overflow     count saturated this frame, qualified by result_valid
module unary_prod_decoder #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             spike_in,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WW-1:0]    wcnt;
  logic             ovf;

  logic             sat_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  // Saturating accumulate of the current sample; also feeds the
  // result register directly on the last sample of the frame.
  always_comb begin
    sat_hit = spike_in && (count == MAX);
    cnt_nxt = count;
    if (spike_in && !sat_hit) begin
      cnt_nxt = count + 1'b1;
    end
    ovf_nxt = ovf | sat_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      wcnt         <= '0;
      ovf          <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= COUNT;
            busy  <= 1'b1;
            count <= '0;
            wcnt  <= '0;
            ovf   <= 1'b0;
          end
        end
        COUNT: begin
          count <= cnt_nxt;
          ovf   <= ovf_nxt;
          wcnt  <= wcnt + 1'b1;
          if (wcnt == LAST) begin
            state        <= HOLD;
            busy         <= 1'b0;
            result       <= cnt_nxt;
            overflow     <= ovf_nxt;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          // start only matters when it coincides with acceptance,
          // giving back-to-back frames with no idle gap.
          if (result_ready) begin
            result_valid <= 1'b0;
            if (start) begin
              state <= COUNT;
              busy  <= 1'b1;
              count <= '0;
              wcnt  <= '0;
              ovf   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_prod_decoder.sv
// Directed testbench for unary_prod_decoder (WINDOW=256 and WINDOW=1).
module tb_unary_prod_decoder;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       spike_in;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       busy;
  logic       overflow;

  logic       start1;
  logic       spike1;
  logic [7:0] result1;
  logic       valid1;
  logic       ready1;
  logic       busy1;
  logic       ovf1;

  int checks;
  int failures;

  unary_prod_decoder #(.WINDOW(256), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .spike_in(spike_in),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .overflow(overflow)
  );

  unary_prod_decoder #(.WINDOW(1), .CNT_W(8)) dut1 (
    .clk(clk),
    .reset_n(reset_n),
    .start(start1),
    .spike_in(spike1),
    .result(result1),
    .result_valid(valid1),
    .result_ready(ready1),
    .busy(busy1),
    .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    spike_in = 1'b0;
    result_ready = 1'b0;
    start1 = 1'b0;
    spike1 = 1'b0;
    ready1 = 1'b0;
    step();
    step();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 ||
        overflow !== 1'b0 || result !== 8'd0) begin
      failures++;
      $display("FAIL reset: v=%b b=%b o=%b r=%0d want 0 0 0 0",
               result_valid, busy, overflow, result);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int spikes;
    result_ready = 1'b1;
    start = 1'b1;
    spike_in = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    spikes = 0;
    for (int i = 0; i < 256; i++) begin
      spike_in = (i == 0 || i == 7 || i == 50 ||
                  i == 51 || i == 200 || i == 255);
      if (i == 255) begin
        checks++;
        if (result_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_early: valid=%b want 0", result_valid);
        end
      end
      step();
    end
    spike_in = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd6 ||
        overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: v=%b r=%0d o=%b b=%b want 1 6 0 0",
               result_valid, result, overflow, busy);
    end
    step();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept: v=%b b=%b want 0 0",
               result_valid, busy);
    end
  endtask

  task automatic test_saturate();
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    spike_in = 1'b1;
    for (int i = 0; i < 256; i++) step();
    spike_in = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd255 ||
        overflow !== 1'b1) begin
      failures++;
      $display("FAIL saturate: v=%b r=%0d o=%b want 1 255 1",
               result_valid, result, overflow);
    end
  endtask

  task automatic test_backpressure();
    // Continues holding the saturated result from the previous task.
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      spike_in = (i == 5);
      step();
      checks++;
      if (result_valid !== 1'b1 || result !== 8'd255 ||
          overflow !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%b r=%0d o=%b b=%b want 1 255 1 0",
                 i, result_valid, result, overflow, busy);
      end
    end
    start = 1'b0;
    spike_in = 1'b0;
    result_ready = 1'b1;
    step();
    step();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: v=%b b=%b want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      spike_in = (i == 10 || i == 20 || i == 30);
      step();
    end
    spike_in = 1'b0;
    step();
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd3) begin
      failures++;
      $display("FAIL b2b_first: v=%b r=%0d want 1 3",
               result_valid, result);
    end
    result_ready = 1'b1;
    start = 1'b1;
    spike_in = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: v=%b b=%b want 0 1",
               result_valid, busy);
    end
    // Window already in its first sample cycle.
    for (int i = 0; i < 256; i++) begin
      spike_in = (i == 1 || i == 2 || i == 100 ||
                  i == 128 || i == 254);
      step();
    end
    spike_in = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd5 ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: v=%b r=%0d o=%b want 1 5 0",
               result_valid, result, overflow);
    end
    result_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    result_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    spike_in = 1'b1;
    for (int i = 0; i < 100; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (result_valid === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    spike_in = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_drop: active cycles=%0d want 0", seen);
    end
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      spike_in = (i == 3 || i == 99 || i == 100 || i == 240);
      step();
    end
    spike_in = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== 8'd4 ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_next: v=%b r=%0d o=%b want 1 4 0",
               result_valid, result, overflow);
    end
    result_ready = 1'b1;
    step();
  endtask

  task automatic test_window_one();
    ready1 = 1'b0;
    start1 = 1'b1;
    spike1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
      failures++;
      $display("FAIL w1_count: b=%b v=%b want 1 0", busy1, valid1);
    end
    step();
    spike1 = 1'b0;
    checks++;
    if (valid1 !== 1'b1 || result1 !== 8'd1 || ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL w1_result: v=%b r=%0d o=%b want 1 1 0",
               valid1, result1, ovf1);
    end
    ready1 = 1'b1;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    checks++;
    if (valid1 !== 1'b1 || result1 !== 8'd0) begin
      failures++;
      $display("FAIL w1_zero: v=%b r=%0d want 1 0", valid1, result1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_window_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
